// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the WB, MDU, ID and register-file write-port signals around the
// register-file write arbiter. The master side drives the requests and source
// registers. The slave side (the arbiter) drives grants, hazards and the write port.
interface regfile_write_arbiter_if;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        mdu_issue_i;
    logic [4:0]  mdu_issue_rd_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        hazard_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;

    modport master (
        output wb_we_i, wb_rd_i, wb_data_i,
        output mdu_issue_i, mdu_issue_rd_i,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        output id_rs_i, id_rt_i,
        input  mdu_ready_o, hazard_o, stall_o,
        input  rf_we_o, rf_addr_o, rf_data_o
    );

    modport slave (
        input  wb_we_i, wb_rd_i, wb_data_i,
        input  mdu_issue_i, mdu_issue_rd_i,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  id_rs_i, id_rt_i,
        output mdu_ready_o, hazard_o, stall_o,
        output rf_we_o, rf_addr_o, rf_data_o
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU.
// Keeps a busy scoreboard of registers that are waiting for MDU results, and
// raises hazard_o to ID. Optional macro REGARB_STARVE_EN adds a starvation
// counter. With this macro, the MDU can take the port from WB after STARVE_MAX
// lost cycles, and the pipeline is stalled for that one cycle. Without it, the
// MDU only writes when WB is idle.
module regfile_write_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    regfile_write_arbiter_if.slave bus
);

    // The counter must be able to hold STARVE_MAX.
    localparam bit unused_cfg_ok = (STARVE_MAX < (1 << CNT_W));

    logic        steal;
    logic        mdu_gnt;
    logic        wb_gnt;

    logic        rf_we_q,      rf_we_d;
    logic [4:0]  rf_addr_q,    rf_addr_d;
    logic [31:0] rf_data_q,    rf_data_d;
    logic        rf_src_mdu_q, rf_src_mdu_d;
    logic [31:0] busy_q,       busy_d;

`ifdef REGARB_STARVE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count the cycles that a waiting MDU result loses. The count saturates at STARVE_MAX.
    always_comb begin
        cnt_d = '0;
        if (bus.mdu_valid_i && !mdu_gnt) begin
            cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // Grant selection: WB has priority unless the MDU has starved long enough.
    always_comb begin
        steal = 1'b0;
`ifdef REGARB_STARVE_EN
        steal = bus.wb_we_i & bus.mdu_valid_i & (cnt_q == CNT_W'(STARVE_MAX));
`endif
        mdu_gnt = bus.mdu_valid_i & (~bus.wb_we_i | steal);
        wb_gnt  = bus.wb_we_i & ~mdu_gnt;
    end

    // Next write-port value from the winner. A write to r0 is accepted but not performed.
    always_comb begin
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_data_d    = rf_data_q;
        rf_src_mdu_d = rf_src_mdu_q;
        if (mdu_gnt) begin
            rf_we_d      = (bus.mdu_rd_i != 5'd0);
            rf_addr_d    = bus.mdu_rd_i;
            rf_data_d    = bus.mdu_data_i;
            rf_src_mdu_d = 1'b1;
        end else if (wb_gnt) begin
            rf_we_d      = (bus.wb_rd_i != 5'd0);
            rf_addr_d    = bus.wb_rd_i;
            rf_data_d    = bus.wb_data_i;
            rf_src_mdu_d = 1'b0;
        end
    end

    // Scoreboard update: an MDU write clears the register's busy bit. A new issue
    // to the same register at the same edge keeps it set.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q && rf_src_mdu_q) begin
            busy_d[rf_addr_q] = 1'b0;
        end
        if (bus.mdu_issue_i && (bus.mdu_issue_rd_i != 5'd0)) begin
            busy_d[bus.mdu_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write-port and scoreboard registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_we_q      <= 1'b0;
            rf_addr_q    <= 5'd0;
            rf_data_q    <= 32'd0;
            rf_src_mdu_q <= 1'b0;
            busy_q       <= 32'd0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            rf_src_mdu_q <= rf_src_mdu_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mdu_ready_o = mdu_gnt;
    assign bus.stall_o     = steal;
    assign bus.hazard_o    = busy_q[bus.id_rs_i] | busy_q[bus.id_rt_i];
    assign bus.rf_we_o     = rf_we_q;
    assign bus.rf_addr_o   = rf_addr_q;
    assign bus.rf_data_o   = rf_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter with hand-computed expectations.
// The expected starvation behaviour depends on whether REGARB_STARVE_EN is defined.
module tb_regfile_write_arbiter;

    logic clk_i;
    logic rst_i;
    int   errors;
    int   checks;

    regfile_write_arbiter_if rif();

    regfile_write_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (rif.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        rif.wb_we_i = 0; rif.wb_rd_i = 0; rif.wb_data_i = 0;
        rif.mdu_issue_i = 0; rif.mdu_issue_rd_i = 0;
        rif.mdu_valid_i = 0; rif.mdu_rd_i = 0; rif.mdu_data_i = 0;
        rif.id_rs_i = 0; rif.id_rt_i = 0;
    endtask

    task automatic test_reset;
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", rif.rf_we_o); end
        checks++; if (rif.rf_addr_o !== 5'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rif.rf_addr_o); end
        checks++; if (rif.rf_data_o !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rif.rf_data_o); end
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", rif.hazard_o); end
        checks++; if (rif.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", rif.stall_o); end
    endtask

    task automatic test_wb_only;
        rif.wb_we_i = 1; rif.wb_rd_i = 5; rif.wb_data_i = 32'hDEADBEEF;
        #1;
        checks++; if (rif.mdu_ready_o !== 1'b0) begin errors++; $display("FAIL wb_ready got=%b exp=0", rif.mdu_ready_o); end
        checks++; if (rif.stall_o !== 1'b0) begin errors++; $display("FAIL wb_stall got=%b exp=0", rif.stall_o); end
        step;
        rif.wb_we_i = 0;
        checks++; if (rif.rf_we_o !== 1'b1) begin errors++; $display("FAIL wb_we got=%b exp=1", rif.rf_we_o); end
        checks++; if (rif.rf_addr_o !== 5'd5) begin errors++; $display("FAIL wb_addr got=%0d exp=5", rif.rf_addr_o); end
        checks++; if (rif.rf_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_data got=%h exp=deadbeef", rif.rf_data_o); end
        step;
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL wb_idle_we got=%b exp=0", rif.rf_we_o); end
        checks++; if (rif.rf_addr_o !== 5'd5) begin errors++; $display("FAIL wb_hold_addr got=%0d exp=5", rif.rf_addr_o); end
        checks++; if (rif.rf_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_hold_data got=%h exp=deadbeef", rif.rf_data_o); end
    endtask

    task automatic test_mdu_hazard;
        rif.id_rs_i = 8;
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 8;
        #1;
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL haz_pre got=%b exp=0", rif.hazard_o); end
        step;
        rif.mdu_issue_i = 0;
        #1;
        checks++; if (rif.hazard_o !== 1'b1) begin errors++; $display("FAIL haz_set got=%b exp=1", rif.hazard_o); end
        rif.id_rs_i = 0; rif.id_rt_i = 8;
        #1;
        checks++; if (rif.hazard_o !== 1'b1) begin errors++; $display("FAIL haz_rt got=%b exp=1", rif.hazard_o); end
        rif.id_rs_i = 8; rif.id_rt_i = 0;
        step;
        rif.mdu_valid_i = 1; rif.mdu_rd_i = 8; rif.mdu_data_i = 32'h12345678;
        #1;
        checks++; if (rif.mdu_ready_o !== 1'b1) begin errors++; $display("FAIL mdu_ready got=%b exp=1", rif.mdu_ready_o); end
        step;
        rif.mdu_valid_i = 0;
        checks++; if (rif.rf_we_o !== 1'b1) begin errors++; $display("FAIL mdu_we got=%b exp=1", rif.rf_we_o); end
        checks++; if (rif.rf_addr_o !== 5'd8) begin errors++; $display("FAIL mdu_addr got=%0d exp=8", rif.rf_addr_o); end
        checks++; if (rif.rf_data_o !== 32'h12345678) begin errors++; $display("FAIL mdu_data got=%h exp=12345678", rif.rf_data_o); end
        checks++; if (rif.hazard_o !== 1'b1) begin errors++; $display("FAIL haz_t1 got=%b exp=1", rif.hazard_o); end
        step;
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL haz_clr got=%b exp=0", rif.hazard_o); end
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL mdu_we_off got=%b exp=0", rif.rf_we_o); end
        rif.id_rs_i = 0;
    endtask

    task automatic test_starvation;
        logic exp_gnt;
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 12;
        step;
        rif.mdu_issue_i = 0;
        rif.wb_we_i = 1; rif.wb_rd_i = 10; rif.wb_data_i = 32'h000000A0;
        rif.mdu_valid_i = 1; rif.mdu_rd_i = 12; rif.mdu_data_i = 32'h000000B0;
        for (int c = 1; c <= 5; c++) begin
`ifdef REGARB_STARVE_EN
            exp_gnt = (c == 5);
`else
            exp_gnt = 1'b0;
`endif
            #1;
            checks++; if (rif.mdu_ready_o !== exp_gnt) begin errors++; $display("FAIL starve_ready c=%0d got=%b exp=%b", c, rif.mdu_ready_o, exp_gnt); end
            checks++; if (rif.stall_o !== exp_gnt) begin errors++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, rif.stall_o, exp_gnt); end
            step;
            checks++; if (rif.rf_addr_o !== (exp_gnt ? 5'd12 : 5'd10)) begin errors++; $display("FAIL starve_addr c=%0d got=%0d", c, rif.rf_addr_o); end
            checks++; if (rif.rf_data_o !== (exp_gnt ? 32'hB0 : 32'hA0)) begin errors++; $display("FAIL starve_data c=%0d got=%h", c, rif.rf_data_o); end
            if (exp_gnt) rif.mdu_valid_i = 0;
        end
`ifdef REGARB_STARVE_EN
        #1;
        checks++; if (rif.stall_o !== 1'b0) begin errors++; $display("FAIL replay_stall got=%b exp=0", rif.stall_o); end
        step;
        checks++; if (rif.rf_we_o !== 1'b1 || rif.rf_addr_o !== 5'd10 || rif.rf_data_o !== 32'hA0)
            begin errors++; $display("FAIL replay_wb got=%b/%0d/%h exp=1/10/a0", rif.rf_we_o, rif.rf_addr_o, rif.rf_data_o); end
        rif.wb_we_i = 0;
`else
        rif.wb_we_i = 0;
        #1;
        checks++; if (rif.mdu_ready_o !== 1'b1) begin errors++; $display("FAIL lowpri_ready got=%b exp=1", rif.mdu_ready_o); end
        checks++; if (rif.stall_o !== 1'b0) begin errors++; $display("FAIL lowpri_stall got=%b exp=0", rif.stall_o); end
        step;
        rif.mdu_valid_i = 0;
        checks++; if (rif.rf_we_o !== 1'b1 || rif.rf_addr_o !== 5'd12 || rif.rf_data_o !== 32'hB0)
            begin errors++; $display("FAIL lowpri_wr got=%b/%0d/%h exp=1/12/b0", rif.rf_we_o, rif.rf_addr_o, rif.rf_data_o); end
`endif
        step;
        rif.id_rs_i = 12;
        #1;
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL starve_haz got=%b exp=0", rif.hazard_o); end
        rif.id_rs_i = 0;
    endtask

    task automatic test_r0;
        rif.wb_we_i = 1; rif.wb_rd_i = 0; rif.wb_data_i = 32'h55;
        step;
        rif.wb_we_i = 0;
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL r0_wb_we got=%b exp=0", rif.rf_we_o); end
        rif.mdu_valid_i = 1; rif.mdu_rd_i = 0; rif.mdu_data_i = 32'h66;
        #1;
        checks++; if (rif.mdu_ready_o !== 1'b1) begin errors++; $display("FAIL r0_mdu_ready got=%b exp=1", rif.mdu_ready_o); end
        step;
        rif.mdu_valid_i = 0;
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL r0_mdu_we got=%b exp=0", rif.rf_we_o); end
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 0;
        step;
        rif.mdu_issue_i = 0;
        rif.id_rs_i = 0; rif.id_rt_i = 0;
        #1;
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL r0_hazard got=%b exp=0", rif.hazard_o); end
    endtask

    task automatic test_set_clear_same;
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 3;
        step;
        rif.mdu_issue_i = 0;
        rif.mdu_valid_i = 1; rif.mdu_rd_i = 3; rif.mdu_data_i = 32'h33;
        step;
        rif.mdu_valid_i = 0;
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 3;
        checks++; if (rif.rf_we_o !== 1'b1 || rif.rf_addr_o !== 5'd3) begin errors++; $display("FAIL same_commit got=%b/%0d exp=1/3", rif.rf_we_o, rif.rf_addr_o); end
        step;
        rif.mdu_issue_i = 0;
        rif.id_rs_i = 3;
        #1;
        checks++; if (rif.hazard_o !== 1'b1) begin errors++; $display("FAIL same_setwins got=%b exp=1", rif.hazard_o); end
        rif.mdu_valid_i = 1;
        step;
        rif.mdu_valid_i = 0;
        step;
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL same_cleared got=%b exp=0", rif.hazard_o); end
        rif.id_rs_i = 0;
    endtask

    task automatic test_reset_midwait;
        rif.mdu_issue_i = 1; rif.mdu_issue_rd_i = 7;
        step;
        rif.mdu_issue_i = 0;
        rif.id_rt_i = 7;
        rif.wb_we_i = 1; rif.wb_rd_i = 9; rif.wb_data_i = 32'h99;
        rif.mdu_valid_i = 1; rif.mdu_rd_i = 7; rif.mdu_data_i = 32'h77;
        step;
        step;
        checks++; if (rif.rf_addr_o !== 5'd9 || rif.hazard_o !== 1'b1) begin errors++; $display("FAIL midwait_pre got=%0d/%b exp=9/1", rif.rf_addr_o, rif.hazard_o); end
        #1;
        rst_i = 0;
        #1;
        checks++; if (rif.rf_we_o !== 1'b0) begin errors++; $display("FAIL midrst_we got=%b exp=0", rif.rf_we_o); end
        checks++; if (rif.rf_addr_o !== 5'd0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", rif.rf_addr_o); end
        checks++; if (rif.rf_data_o !== 32'd0) begin errors++; $display("FAIL midrst_data got=%h exp=0", rif.rf_data_o); end
        checks++; if (rif.hazard_o !== 1'b0) begin errors++; $display("FAIL midrst_hazard got=%b exp=0", rif.hazard_o); end
        checks++; if (rif.stall_o !== 1'b0 || rif.mdu_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_grant got=%b/%b exp=0/0", rif.stall_o, rif.mdu_ready_o); end
        idle_inputs();
        step;
        rst_i = 1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_i  = 0;
        idle_inputs();
        step;
        step;
        test_reset();
        rst_i = 1;
        step;
        test_wb_only();
        test_mdu_hazard();
        test_starvation();
        test_r0();
        test_set_clear_same();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
